audio_level_meter: RTL
======================

# audio_level_meter

Parametrised windowed audio peak meter with peak-hold and decay. It sits between `Audio_Capture` and the LED, 7-segment and OLED volume displays, and is the next generation of the `intensity` peak detector. It takes offset-binary mic samples qualified by a strobe and tracks the maximum magnitude about mid-scale over a fixed window of samples. At each window close it quantises that peak into a level, a thermometer bar and a decaying peak-hold marker.

## Interface
Parameters:
- `SAMPLE_W`, 12, sample width; samples are unsigned offset-binary, mid-scale `MID = 2^(SAMPLE_W-1)`.
- `WINDOW`, 4000, valid samples per measurement window; must be ≥ 2.
- `LEVELS`, 16, number of display levels; must be ≤ `2^(SAMPLE_W-1)`.
- `HOLD_WINDOWS`, 4, windows the peak-hold stays frozen before it starts to decay; may be 0.
- `LW`, derived: `$clog2(LEVELS+1)`.

Ports:
- `clk`, in, 1, system clock (100 MHz).
- `resn`, in, 1, asynchronous active-low reset.
- `enable`, in, 1, meter run enable.
- `sample_valid`, in, 1, one-cycle strobe marking a new sample (20 kHz rate).
- `sample`, in, `SAMPLE_W`, mic sample.
- `peak`, out, `SAMPLE_W-1`, peak magnitude of the last closed window.
- `level`, out, `LW`, quantised level of the last window, 0..`LEVELS`.
- `bar`, out, `LEVELS`, thermometer; bit i = (i < `level`).
- `hold_level`, out, `LW`, peak-hold level.
- `hold_mark`, out, `LEVELS`, one-hot at bit `hold_level-1`; all zero when `hold_level` = 0.
- `level_valid`, out, 1, one-cycle pulse when the outputs above update.

## Operation
- Magnitude: `mag = (sample >= MID) ? sample-MID : MID-1-sample`. Width is `SAMPLE_W-1` and the result never overflows, so both 0 and full scale give `2^(SAMPLE_W-1)-1`.
- States:
  - IDLE: entered while `enable` = 0; accumulator and counter are held at 0.
  - ACCUM: running max `acc`, sample count `cnt`.
  - LATCH: one cycle of window close.
- Transitions:
  - IDLE→ACCUM when `enable` = 1.
  - ACCUM→LATCH on the edge that accepts valid sample number `WINDOW`. That sample is included in `acc`.
  - LATCH→ACCUM unconditionally.
  - Any state→IDLE when `enable` = 0. This discards a partial window, and no `level_valid` is issued.
- LATCH edge:
  - `peak <= acc`.
  - `level <= min(LEVELS, ((acc+1)*LEVELS) >> (SAMPLE_W-1))`. The intermediate is `SAMPLE_W-1+LW` bits wide.
  - `bar` and `hold_mark` are registered from the new values.
  - `level_valid` pulses.
  - A `sample_valid` in the LATCH cycle is the first sample of the next window: `acc <= mag`, `cnt <= 1`. Otherwise `acc <= 0`, `cnt <= 0`. No sample is ever lost.
- Peak-hold, evaluated on the LATCH edge with `L` = new level:
  - If `L >= hold_level`: `hold_level <= L`, `hold_cnt <= HOLD_WINDOWS`.
  - Else if `hold_cnt != 0`: `hold_cnt <= hold_cnt-1`.
  - Else: `hold_level <= hold_level-1`. This never drops below `L`, because `L < hold_level`.
- Outputs retain their last values while in IDLE.

## Timing
- Reset (`resn` = 0, asynchronous): state IDLE; `acc`, `cnt`, `peak`, `level`, `bar`, `hold_level`, `hold_mark`, `hold_cnt` and `level_valid` all 0.
- Reset mid-window discards the window. After release, the first window needs the full `WINDOW` valid samples.
- Latency: outputs update and `level_valid` is high on the edge after the edge accepting the `WINDOW`-th sample. That is a 1-cycle state latency, with outputs registered.
- `sample_valid` on every cycle is legal. The window period is then exactly `WINDOW` cycles.
- `sample_valid` while `enable` = 0 is ignored.

## Structure
- Package `audio_meter_pkg`:
  - state enum (IDLE, ACCUM, LATCH);
  - function `mag_of(sample)`;
  - function `quantise(acc)`;
  - derived width constants.
- Sub-module `peak_hold`: registered `hold_level`/`hold_cnt` logic, updated on a `latch` strobe with `L` as input.
- Top module: FSM, accumulator, counter, output registers, thermometer and one-hot decode.

## Test plan
All scenarios use `SAMPLE_W`=12, `WINDOW`=4, `LEVELS`=16, `HOLD_WINDOWS`=2.
1. **Reset:** assert `resn`=0 after 2 samples of a window → all outputs 0. After release, 4 samples of 2048 → `peak`=0, `level`=0, `bar`=0x0000, one `level_valid`.
2. **Quantisation:** samples {2048, 3000, 1000, 2100} → mags {0, 952, 1047, 52}. Expect `peak`=1047, `level`=8, `bar`=0x00FF, `hold_level`=8, `hold_mark`=0x0080.
3. **Full scale:** window {4095, 0, 2048, 2048} → `peak`=2047, `level`=16, `bar`=0xFFFF, `hold_mark`=0x8000.
4. **Hold and decay:** one window at level 12 (peak 1535), then silent windows → `level`=0 each time. `hold_level` sequence is 12, 12, 12, 11, 10, …, 0 and then stays 0.
5. **Back-to-back:** `sample_valid` every cycle for 12 cycles → exactly 3 `level_valid` pulses, 4 cycles apart. The sample arriving in each LATCH cycle is counted in the following window (check with one loud sample placed there).
6. **Enable drop:** drop `enable` after 2 samples → no `level_valid`, outputs unchanged. Re-enable → the next `level_valid` comes only after 4 further samples.

Source files
------------

// File: rtl/audio_meter_pkg.sv
// Shared types and arithmetic helpers for the audio level meter.
// Helpers work on 32-bit values; callers size the result to their own widths.
package audio_meter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    LATCH = 2'd2
  } meter_state_t;

  localparam int DEF_SAMPLE_W     = 12;
  localparam int DEF_WINDOW       = 4000;
  localparam int DEF_LEVELS       = 16;
  localparam int DEF_HOLD_WINDOWS = 4;
  localparam int DEF_LW           = $clog2(DEF_LEVELS + 1);

  // Distance from mid-scale; the negative side is folded so that it never overflows.
  function automatic int unsigned mag_of(input int unsigned sample, input int unsigned sample_w);
    int unsigned mid;
    mid = 32'd1 << (sample_w - 1);
    return (sample >= mid) ? (sample - mid) : (mid - 32'd1 - sample);
  endfunction

  function automatic int unsigned quantise(input int unsigned acc, input int unsigned sample_w,
                                           input int unsigned levels);
    int unsigned q;
    q = ((acc + 32'd1) * levels) >> (sample_w - 1);
    return (q > levels) ? levels : q;
  endfunction

endpackage

// File: rtl/peak_hold.sv
// Peak-hold marker: jumps up to a new level immediately, freezes for
// HOLD_WINDOWS windows, then decays one level per window.
module peak_hold #(
  parameter int LW           = 5,
  parameter int HOLD_WINDOWS = 4
) (
  input  logic          clk,
  input  logic          resn,
  input  logic          latch,
  input  logic [LW-1:0] level_in,
  output logic [LW-1:0] hold_level,
  output logic [LW-1:0] hold_next
);

  localparam int HW = (HOLD_WINDOWS > 0) ? $clog2(HOLD_WINDOWS + 1) : 1;

  logic [HW-1:0] hold_cnt, hold_cnt_d;

  always_comb begin
    hold_next  = hold_level;
    hold_cnt_d = hold_cnt;
    if (level_in >= hold_level) begin
      hold_next  = level_in;
      hold_cnt_d = HW'(HOLD_WINDOWS);
    end else if (hold_cnt != '0) begin
      hold_cnt_d = hold_cnt - HW'(1);
    end else begin
      hold_next = hold_level - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      hold_level <= '0;
      hold_cnt   <= '0;
    end else if (latch) begin
      hold_level <= hold_next;
      hold_cnt   <= hold_cnt_d;
    end
  end

endmodule

// File: rtl/audio_level_meter.sv
// Windowed peak meter: tracks max |sample - mid| over WINDOW samples and
// publishes level, thermometer bar and a decaying peak-hold marker per window.
//
//   state | meaning
//   IDLE  | disabled; accumulator and counter held at zero
//   ACCUM | collecting running max over the current window
//   LATCH | window close; outputs load, a sample here starts the next window
module audio_level_meter
  import audio_meter_pkg::*;
#(
  parameter int SAMPLE_W     = DEF_SAMPLE_W,
  parameter int WINDOW       = DEF_WINDOW,
  parameter int LEVELS       = DEF_LEVELS,
  parameter int HOLD_WINDOWS = DEF_HOLD_WINDOWS,
  parameter int LW           = $clog2(LEVELS + 1)
) (
  input  logic                clk,
  input  logic                resn,
  input  logic                enable,
  input  logic                sample_valid,
  input  logic [SAMPLE_W-1:0] sample,
  output logic [SAMPLE_W-2:0] peak,
  output logic [LW-1:0]       level,
  output logic [LEVELS-1:0]   bar,
  output logic [LW-1:0]       hold_level,
  output logic [LEVELS-1:0]   hold_mark,
  output logic                level_valid
);

  localparam int MW = SAMPLE_W - 1;
  localparam int CW = $clog2(WINDOW + 1);

  meter_state_t      state_q, state_d;
  logic [MW-1:0]     acc_q, mag;
  logic [CW-1:0]     cnt_q;
  logic [LW-1:0]     level_d, hold_next;
  logic [LEVELS-1:0] bar_d, mark_d;
  logic              last_sample, latch;

  always_comb begin
    mag         = MW'(mag_of(32'(sample), SAMPLE_W));
    level_d     = LW'(quantise(32'(acc_q), SAMPLE_W, LEVELS));
    last_sample = sample_valid && (cnt_q == CW'(WINDOW - 1));
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = ACCUM;
      ACCUM:   if (last_sample) state_d = LATCH;
      LATCH:   state_d = ACCUM;
      default: state_d = IDLE;
    endcase
    if (!enable) state_d = IDLE;
  end

  always_comb begin
    latch = (state_q == LATCH);
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (!enable || state_q == IDLE) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (latch) begin
      acc_q <= sample_valid ? mag : '0;
      cnt_q <= sample_valid ? CW'(1) : '0;
    end else if (sample_valid) begin
      if (mag > acc_q) acc_q <= mag;
      cnt_q <= cnt_q + CW'(1);
    end
  end

  peak_hold #(
    .LW           (LW),
    .HOLD_WINDOWS (HOLD_WINDOWS)
  ) u_peak_hold (
    .clk        (clk),
    .resn       (resn),
    .latch      (latch),
    .level_in   (level_d),
    .hold_level (hold_level),
    .hold_next  (hold_next)
  );

  // Decode from the values about to be loaded so bar/mark stay aligned with level/hold_level.
  always_comb begin
    bar_d  = '0;
    mark_d = '0;
    for (int i = 0; i < LEVELS; i++) begin
      bar_d[i]  = (LW'(i) < level_d);
      mark_d[i] = (LW'(i + 1) == hold_next);
    end
  end

  always_ff @(posedge clk or negedge resn) begin
    if (!resn) begin
      peak        <= '0;
      level       <= '0;
      bar         <= '0;
      hold_mark   <= '0;
      level_valid <= 1'b0;
    end else begin
      level_valid <= latch;
      if (latch) begin
        peak      <= acc_q;
        level     <= level_d;
        bar       <= bar_d;
        hold_mark <= mark_d;
      end
    end
  end

endmodule
